midway_video_scanout: RTL

- Read-side counterpart to the CPU memory block: walks the 1bpp bitmap in the shared 8 KB work/video RAM and serialises it to pixels.
- Generates raster counters, sync and blank, and the two per-frame CPU interrupt vectors (RST 1 mid-screen, RST 2 end-of-screen).
- Sits between the shared RAM's video read port and the video output/rotation logic.

---
 rtl/midway_video_scanout.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/midway_video_scanout.sv
// midway_video_scanout: raster timing, 1bpp bitmap fetch/serialiser and RST 1 / RST 2 interrupt source.
// Define FLIP_SCREEN_EN to build the cocktail-flip (180 degree rotation) path controlled by Flip.
module midway_video_scanout #(
  parameter int          H_TOTAL   = 320,
  parameter int          V_TOTAL   = 262,
  parameter int          V_ACTIVE  = 224,
  parameter int          HS_START  = 280,
  parameter int          HS_LEN    = 24,
  parameter int          VS_START  = 236,
  parameter int          VS_LEN    = 4,
  parameter int          MID_LINE  = 96,
  parameter logic [12:0] VRAM_BASE = 13'h0400
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Pix_Ce,
  output logic [12:0] Vid_Addr,
  output logic        Vid_Rd,
  input  logic [7:0]  Vid_Data,
  output logic [8:0]  Hcount,
  output logic [8:0]  Vcount,
  output logic        Pixel,
  output logic        Hblank,
  output logic        Vblank,
  output logic        Hsync,
  output logic        Vsync,
  output logic        Irq,
  output logic [7:0]  Irq_Vec,
  input  logic        Irq_Ack,
  input  logic        Flip
);

  localparam logic [8:0] H_LAST    = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST    = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_ACT     = 9'(V_ACTIVE);
  localparam logic [8:0] HS_FIRST  = 9'(HS_START);
  localparam logic [8:0] HS_END    = 9'(HS_START + HS_LEN);
  localparam logic [8:0] VS_FIRST  = 9'(VS_START);
  localparam logic [8:0] VS_END    = 9'(VS_START + VS_LEN);
  localparam logic [8:0] MID       = 9'(MID_LINE);
  localparam logic [8:0] ACT_FIRST = 9'd8;
  localparam logic [8:0] ACT_END   = 9'd264;
  localparam logic [7:0] RST1_OP   = 8'hCF;
  localparam logic [7:0] RST2_OP   = 8'hD7;

  typedef enum logic [1:0] {IDLE, READ, LATCH} fetch_state_t;

  fetch_state_t state, state_nxt;
  logic [8:0]   h_nxt, v_nxt;
  logic         line_wrap, fetch_go, irq_event, pix_active;
  logic [7:0]   row;
  logic [4:0]   col;
  logic [12:0]  fetch_addr;
  logic [7:0]   load_byte;
  logic [7:0]   hold_p1;
  logic [7:0]   shift_p2;

`ifdef FLIP_SCREEN_EN
  localparam logic [7:0] ROW_LAST = 8'(V_ACTIVE - 1);

  logic flip_frame, flip_now;

  function automatic logic [7:0] bit_rev(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // The first fetch of a frame coincides with the Flip sample, so it sees Flip directly.
  assign flip_now  = (Vcount == 9'd0 && Hcount == 9'd0) ? Flip : flip_frame;
  assign row       = flip_now ? (ROW_LAST - Vcount[7:0]) : Vcount[7:0];
  assign col       = flip_now ? ~Hcount[7:3] : Hcount[7:3];
  assign load_byte = flip_frame ? bit_rev(hold_p1) : hold_p1;

  always_ff @(posedge Clock) begin
    if (!Reset_n)
      flip_frame <= 1'b0;
    else if (Pix_Ce && Vcount == 9'd0 && Hcount == 9'd0)
      flip_frame <= Flip;
  end
`else
  logic flip_unused;

  assign flip_unused = Flip;
  assign row         = Vcount[7:0];
  assign col         = Hcount[7:3];
  assign load_byte   = hold_p1;
`endif

  always_comb begin
    line_wrap  = (Hcount == H_LAST);
    h_nxt      = line_wrap ? 9'd0 : Hcount + 9'd1;
    v_nxt      = Vcount;
    if (line_wrap) v_nxt = (Vcount == V_LAST) ? 9'd0 : Vcount + 9'd1;
    fetch_go   = Pix_Ce && (Vcount < V_ACT) && !Hcount[8] && (Hcount[2:0] == 3'd0);
    irq_event  = Pix_Ce && line_wrap && (v_nxt == MID || v_nxt == V_ACT);
    fetch_addr = VRAM_BASE + {row, col};
    pix_active = (Vcount < V_ACT) && (Hcount >= ACT_FIRST) && (Hcount < ACT_END);
  end

  assign Pixel = shift_p2[0] & pix_active;

  always_ff @(posedge Clock) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Vid_Rd    = 1'b0;
    case (state)
      IDLE:    if (fetch_go) state_nxt = READ;
      READ: begin
        Vid_Rd    = 1'b1;
        state_nxt = LATCH;
      end
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      Hcount   <= '0;
      Vcount   <= '0;
      Hblank   <= 1'b0;
      Vblank   <= 1'b0;
      Hsync    <= 1'b0;
      Vsync    <= 1'b0;
      Vid_Addr <= '0;
      hold_p1  <= '0;
      shift_p2 <= '0;
      Irq      <= 1'b0;
      Irq_Vec  <= '0;
    end else begin
      // Stage 0 -> 1: address issue, then RAM data captured one Clock after the read strobe.
      if (fetch_go)       Vid_Addr <= fetch_addr;
      if (state == LATCH) hold_p1  <= Vid_Data;
      // Stage 1 -> 2: raster advance; shifter reload at the last pixel of each 8-pixel group.
      if (Pix_Ce) begin
        Hcount   <= h_nxt;
        Vcount   <= v_nxt;
        Hblank   <= !((h_nxt >= ACT_FIRST) && (h_nxt < ACT_END));
        Vblank   <= (v_nxt >= V_ACT);
        Hsync    <= (h_nxt >= HS_FIRST) && (h_nxt < HS_END);
        Vsync    <= (v_nxt >= VS_FIRST) && (v_nxt < VS_END);
        shift_p2 <= (Hcount[2:0] == 3'd7) ? load_byte : {1'b0, shift_p2[7:1]};
      end
      // A line event outranks a simultaneous acknowledge.
      if (irq_event) begin
        Irq     <= 1'b1;
        Irq_Vec <= (v_nxt == MID) ? RST1_OP : RST2_OP;
      end else if (Irq_Ack) begin
        Irq <= 1'b0;
      end
    end
  end

endmodule
